mole_scheduler: RTL and testbench

Round controller for the whack-an-engineer game. Sequences one timed game: it gaps, pops a pseudo-random mole, and judges the player's keyboard hole selection as hit, miss or timeout. It keeps the score and the seconds countdown, and drives the mole LEDs/VGA helper and the HEX score/countdown displays. It sits between the keyboard decoder (hole index and valid pulse) and the display/audio blocks.

---
 rtl/mole_scheduler.sv | 178 +++++++++++++++++
 tb/tb_mole_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Round controller for whack-an-engineer: gap / pop / judge sequencing,
// score and seconds countdown, all outputs registered.
module mole_scheduler #(
  parameter int SEC_CYCLES   = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int MOLE_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES   = 12_500_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [2:0] key_hole,
  output logic [4:0] moles,
  output logic [5:0] countdown,
  output logic [7:0] score,
  output logic       mole_hit,
  output logic       mole_miss,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int PHASE_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int PRESC_W   = $clog2(SEC_CYCLES + 1);
  localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] MOLE_LAST = PHASE_W'(MOLE_CYCLES - 1);
  localparam logic [PRESC_W-1:0] SEC_LAST  = PRESC_W'(SEC_CYCLES - 1);
  localparam logic [5:0]         GAME_SECS = 6'(GAME_SECONDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_SHOW = 3'd2,
    S_HIT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [2:0]           prev_hole_q, prev_hole_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [4:0]           moles_d;
  logic [5:0]           countdown_d;
  logic [7:0]           score_d;
  logic                 hit_d, miss_d, game_over_d;
  logic                 active, sec_wrap, time_up, start_ok;
  logic                 gap_end, mole_end, key_match, key_wrong;
  logic [2:0]           pick;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Fold 0..7 onto 0..4, then step past the previous hole so pops never repeat.
  function automatic logic [2:0] pick_hole(input logic [2:0] r, input logic [2:0] prev);
    logic [2:0] h;
    h = (r >= 3'd5) ? r - 3'd5 : r;
    if (h == prev) h = (h == 3'd4) ? 3'd0 : h + 3'd1;
    return h;
  endfunction

  assign active    = (state_q == S_GAP) || (state_q == S_SHOW) || (state_q == S_HIT);
  assign sec_wrap  = active && (presc_q == SEC_LAST);
  assign time_up   = sec_wrap && (countdown == 6'd1);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign gap_end   = (phase_q == GAP_LAST);
  assign mole_end  = (phase_q == MOLE_LAST);
  assign key_match = key_valid && (key_hole == prev_hole_q);
  assign key_wrong = key_valid && (key_hole < 3'd5) && (key_hole != prev_hole_q);
  assign pick      = pick_hole(lfsr_q[2:0], prev_hole_q);
  assign state     = state_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      moles       <= '0;
      countdown   <= GAME_SECS;
      score       <= '0;
      mole_hit    <= 1'b0;
      mole_miss   <= 1'b0;
      game_over   <= 1'b0;
      lfsr_q      <= 8'hA5;
      prev_hole_q <= '0;
      phase_q     <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      moles       <= moles_d;
      countdown   <= countdown_d;
      score       <= score_d;
      mole_hit    <= hit_d;
      mole_miss   <= miss_d;
      game_over   <= game_over_d;
      lfsr_q      <= lfsr_d;
      prev_hole_q <= prev_hole_d;
      phase_q     <= phase_d;
      presc_q     <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_GAP;
      S_GAP:          if (gap_end) state_d = S_SHOW;
      S_SHOW: begin
        if (key_match)     state_d = S_HIT;
        else if (mole_end) state_d = S_GAP;
      end
      S_HIT:          state_d = S_GAP;
      default:        state_d = S_IDLE;
    endcase
    // The last second expiring overrides whatever the round was doing.
    if (time_up) state_d = S_DONE;
  end

  always_comb begin
    moles_d     = moles;
    countdown_d = countdown;
    score_d     = score;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    lfsr_d      = lfsr_step(lfsr_q);
    prev_hole_d = prev_hole_q;
    phase_d     = phase_q;
    presc_d     = presc_q;

    if (start_ok) begin
      score_d     = '0;
      countdown_d = GAME_SECS;
      presc_d     = '0;
      phase_d     = '0;
      moles_d     = '0;
    end

    if (active) begin
      presc_d = sec_wrap ? '0 : presc_q + 1'b1;
      if (sec_wrap) countdown_d = countdown - 6'd1;
    end

    unique case (state_q)
      S_GAP: phase_d = gap_end ? '0 : phase_q + 1'b1;
      S_SHOW: begin
        if (key_match) begin
          hit_d   = 1'b1;
          score_d = sat_inc(score);
        end else if (mole_end) begin
          miss_d  = 1'b1;
          moles_d = '0;
          phase_d = '0;
        end else begin
          miss_d  = key_wrong;
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIT: begin
        moles_d = '0;
        phase_d = '0;
      end
      default: ;
    endcase

    if ((state_q == S_GAP) && (state_d == S_SHOW)) begin
      moles_d     = 5'd1 << pick;
      prev_hole_d = pick;
    end
    if (time_up) moles_d = '0;

    game_over_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomised scoreboard bench for mole_scheduler against a cycle-count
// reference model, plus a long-round instance for score saturation.
module tb_mole_scheduler;

  localparam int SEC   = 10;
  localparam int GAME  = 3;
  localparam int MOLE  = 6;
  localparam int GAP   = 2;
  localparam int ROUND = GAME * SEC;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] mo;
    logic [5:0] cd;
    logic [7:0] sc;
    logic       hit;
    logic       miss;
    logic       go;
  } exp_t;

  logic       clk;
  logic       resetn, start, key_valid;
  logic [2:0] key_hole;
  logic [4:0] moles;
  logic [5:0] countdown;
  logic [7:0] score;
  logic       mole_hit, mole_miss, game_over;
  logic [2:0] state;

  logic       s_resetn, s_start, s_key_valid;
  logic [2:0] s_key_hole;
  logic [4:0] s_moles;
  logic [5:0] s_countdown;
  logic [7:0] s_score;
  logic       s_mole_hit, s_mole_miss, s_game_over;
  logic [2:0] s_state;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q[$];
  int   sq[$];
  int   s_seen = 0;
  int   s_pressed = 0;
  int   hit_end_seen = 0;
  int   hit_end_state = 0;

  int         m_st = 0, m_e = 0, m_phase = 0, m_score = 0, m_prev = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [4:0] m_moles = '0;
  logic       m_hit = 1'b0, m_miss = 1'b0;

  mole_scheduler #(.SEC_CYCLES(SEC), .GAME_SECONDS(GAME), .MOLE_CYCLES(MOLE), .GAP_CYCLES(GAP)) u_dut (
    .clock(clk), .resetn(resetn), .start(start), .key_valid(key_valid), .key_hole(key_hole),
    .moles(moles), .countdown(countdown), .score(score), .mole_hit(mole_hit),
    .mole_miss(mole_miss), .state(state), .game_over(game_over)
  );

  mole_scheduler #(.SEC_CYCLES(2000), .GAME_SECONDS(63), .MOLE_CYCLES(MOLE), .GAP_CYCLES(GAP)) u_sat (
    .clock(clk), .resetn(s_resetn), .start(s_start), .key_valid(s_key_valid), .key_hole(s_key_hole),
    .moles(s_moles), .countdown(s_countdown), .score(s_score), .mole_hit(s_mole_hit),
    .mole_miss(s_mole_miss), .state(s_state), .game_over(s_game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.st = 3'd0; e.mo = 5'd0; e.cd = 6'(GAME); e.sc = 8'd0;
    e.hit = 1'b0; e.miss = 1'b0; e.go = 1'b0;
    return e;
  endfunction

  function automatic int onehot_idx(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Reference model: countdown derived from cycles elapsed since start.
  always @(posedge clk) begin : model
    int         ns, r, h;
    logic [7:0] l0;
    exp_t       e;
    if (!resetn) begin
      m_st = 0; m_e = 0; m_phase = 0; m_score = 0; m_prev = 0;
      m_lfsr = 8'hA5; m_moles = '0; m_hit = 0; m_miss = 0;
    end else begin
      l0 = m_lfsr;
      m_lfsr = {l0[6:0], l0[7] ^ l0[5] ^ l0[4] ^ l0[3]};
      m_hit = 0; m_miss = 0;
      if (m_st == 0 || m_st == 4) begin
        if (start) begin
          m_st = 1; m_e = 0; m_phase = 0; m_score = 0; m_moles = '0;
        end
      end else begin
        m_e++;
        ns = m_st;
        if (m_st == 1) begin
          if (m_phase == GAP - 1) begin ns = 2; m_phase = 0; end
          else m_phase++;
        end else if (m_st == 2) begin
          if (key_valid && int'(key_hole) == m_prev) begin
            ns = 3; m_hit = 1;
            if (m_score < 255) m_score++;
          end else if (m_phase == MOLE - 1) begin
            m_miss = 1; ns = 1; m_phase = 0; m_moles = '0;
          end else begin
            if (key_valid && key_hole < 5) m_miss = 1;
            m_phase++;
          end
        end else begin
          ns = 1; m_phase = 0; m_moles = '0;
        end
        if (m_e == ROUND) begin
          ns = 4; m_moles = '0;
        end else if (ns == 2 && m_st == 1) begin
          r = int'(l0[2:0]);
          h = (r >= 5) ? r - 5 : r;
          if (h == m_prev) h = (h + 1) % 5;
          m_moles = 5'd1 << h;
          m_prev = h;
        end
        m_st = ns;
      end
    end
    e.st = 3'(m_st); e.mo = m_moles; e.cd = 6'(GAME - m_e / SEC); e.sc = 8'(m_score);
    e.hit = m_hit; e.miss = m_miss; e.go = (m_st == 4);
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!resetn) e = reset_exp();
      check("state", int'(state), int'(e.st));
      check("moles", int'(moles), int'(e.mo));
      check("countdown", int'(countdown), int'(e.cd));
      check("score", int'(score), int'(e.sc));
      check("mole_hit", int'(mole_hit), int'(e.hit));
      check("mole_miss", int'(mole_miss), int'(e.miss));
      check("game_over", int'(game_over), int'(e.go));
    end
  end

  always @(negedge clk) begin : sat_monitor
    if (s_resetn && s_mole_hit) begin
      s_seen++;
      if (sq.size() == 0) check("sat_unexpected_hit", 1, 0);
      else check("sat_score", int'(s_score), sq.pop_front());
    end
  end

  task automatic step(input logic kv, input logic [2:0] kh, input logic st);
    @(posedge clk); #2;
    key_valid = kv; key_hole = kh; start = st;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    resetn = 0; start = 0; key_valid = 0;
    @(posedge clk); #2;
    resetn = 1;
  endtask

  task automatic wait_state(input int st, input int budget);
    int n = 0;
    while (m_st != st && n < budget) begin
      step(0, 3'd0, 0);
      n++;
    end
    check("wait_state", int'(state), st);
  endtask

  initial begin : stim
    resetn = 0; start = 0; key_valid = 0; key_hole = 0;
    s_resetn = 0; s_start = 0; s_key_valid = 0; s_key_hole = 0;
    repeat (3) @(posedge clk);
    #2 resetn = 1;
    repeat ($urandom_range(1, 8)) step(0, 3'd0, 0);

    // First round: wrong key, ignored key, timeout, correct hit, run to DONE.
    step(0, 3'd0, 1);
    wait_state(2, 20);
    step(1, 3'((m_prev + 1) % 5), 0);
    step(1, 3'd6, 0);
    step(0, 3'd0, 0);
    wait_state(1, 20);
    wait_state(2, 20);
    step(1, 3'(m_prev), 0);
    step(0, 3'd0, 0);
    wait_state(4, 60);
    repeat (3) step(1, 3'(m_prev), 0);
    step(0, 3'd0, 1);
    step(0, 3'd0, 0);

    // Asynchronous reset while a mole is lit.
    wait_state(2, 20);
    @(posedge clk); #2;
    resetn = 0; start = 0; key_valid = 0;
    #1;
    check("async_state", int'(state), 0);
    check("async_moles", int'(moles), 0);
    check("async_score", int'(score), 0);
    check("async_countdown", int'(countdown), GAME);
    @(posedge clk); #2;
    resetn = 1;

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        logic       kv, st;
        logic [2:0] kh;
        kv = ($urandom_range(0, 2) == 0);
        kh = ($urandom_range(0, 1) == 0) ? 3'(m_prev) : 3'($urandom_range(0, 7));
        st = (m_st == 0 || m_st == 4) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
        step(kv, kh, st);
      end
    end

    // Correct hit on the very cycle the last second expires.
    do_reset();
    step(0, 3'd0, 1);
    for (int n = 0; n < 60 && m_st != 4; n++) begin
      if (m_st == 2 && m_e == ROUND - 1) begin
        step(1, 3'(m_prev), 0);
        hit_end_seen = 1;
      end else begin
        step(0, 3'd0, 0);
      end
    end
    hit_end_state = int'(state);
    step(0, 3'd0, 0);

    // Score saturation on the long-round instance.
    @(posedge clk); #2 s_resetn = 1;
    @(posedge clk); #2 s_start = 1;
    @(posedge clk); #2 s_start = 0;
    for (int n = 0; n < 4000 && s_pressed < 260; n++) begin
      if (s_state == 3'd2) begin
        s_key_valid = 1;
        s_key_hole = 3'(onehot_idx(s_moles));
        s_pressed++;
        sq.push_back(s_pressed > 255 ? 255 : s_pressed);
      end else begin
        s_key_valid = 0;
      end
      @(posedge clk); #2;
    end
    s_key_valid = 0;
    repeat (4) @(posedge clk);
    #2;

    check("hit_at_end_seen", hit_end_seen, 1);
    check("hit_at_end_state", hit_end_state, 4);
    check("sat_hits_seen", s_seen, 260);
    check("sat_queue_left", sq.size(), 0);
    check("sat_final_score", int'(s_score), 255);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
